// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
package seg_pkg;

    localparam logic [3:0] SEG_BLANK = 4'hF;
    localparam int         NUM_DIG   = 4;

    localparam logic [0:0] ST_DEAD  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    typedef logic [1:0] dig_idx_t;

    // Leading-zero blanking for digit n of {d3,d2,d1,d0}; d0 always stays lit.
    function automatic logic lz_hide(input logic [15:0] d, input dig_idx_t n);
        logic z3;
        logic z2;
        logic z1;
        z3 = (d[15:12] == 4'd0);
        z2 = (d[11:8]  == 4'd0);
        z1 = (d[7:4]   == 4'd0);
        case (n)
            2'd3:    lz_hide = z3;
            2'd2:    lz_hide = z3 & z2;
            2'd1:    lz_hide = z3 & z2 & z1;
            default: lz_hide = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter with a terminal-count pulse; advances only when en_i is high.
module tick_divider #(
    parameter int DIV = 2,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o  = en_i && (cnt_q == LAST);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan of four BCD digits onto a shared code bus with
// dead-time anti-ghosting, per-digit blank/blink and leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int DEAD_CYC  = 16,
    parameter int BLINK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_i,
    input  logic [3:0]  blank_i,
    input  logic [3:0]  blink_i,
    input  logic [3:0]  dp_i,
    input  logic        lz_en_i,
    output logic [3:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] DEAD_LAST = PW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    // first_q marks the snapshot cycle right after reset; the prescaler holds during it.
    logic          first_q;
    logic          slot_adv;
    logic [PW-1:0] presc;
    logic          slot_tc;
    logic [BW-1:0] blink_cnt_unused;
    logic          blink_tc;

    logic [0:0]    state_q, state_d;
    dig_idx_t      idx_q, idx_d;
    logic          blink_off_q, blink_off_d;
    logic          snap;

    logic [15:0]   sh_dig_q, sh_dig_d;
    logic [3:0]    sh_blank_q, sh_blank_d;
    logic [3:0]    sh_blink_q, sh_blink_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic          sh_lz_q, sh_lz_d;

    logic [3:0]    seg_d, an_d;
    logic          dp_d;
    dig_idx_t      dig_n;
    logic [3:0]    code;
    logic          hide;

    assign slot_adv = ~first_q;

    tick_divider #(.DIV(CLK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (slot_adv),
        .cnt_o (presc),
        .tc_o  (slot_tc)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (slot_tc),
        .cnt_o (blink_cnt_unused),
        .tc_o  (blink_tc)
    );

    assign snap        = first_q | (slot_tc & (idx_q == 2'd3));
    assign idx_d       = slot_tc ? idx_q + 2'd1 : idx_q;
    assign blink_off_d = blink_off_q ^ blink_tc;

    assign sh_dig_d   = snap ? digits_i : sh_dig_q;
    assign sh_blank_d = snap ? blank_i  : sh_blank_q;
    assign sh_blink_d = snap ? blink_i  : sh_blink_q;
    assign sh_dp_d    = snap ? dp_i     : sh_dp_q;
    assign sh_lz_d    = snap ? lz_en_i  : sh_lz_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DEAD: begin
                if (DEAD_CYC == 0) begin
                    state_d = ST_DRIVE;
                end else if (slot_adv && presc == DEAD_LAST) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (slot_tc) begin
                    state_d = (DEAD_CYC == 0) ? ST_DRIVE : ST_DEAD;
                end
            end
            default: state_d = ST_DEAD;
        endcase
    end

    // Outputs are computed from next-state values so the registered pins line up with the prescaler.
    always_comb begin
        dig_n = 2'd3 - idx_d;
        code  = sh_dig_d[{dig_n, 2'b00} +: 4];
        hide  = sh_blank_d[dig_n]
              | (sh_blink_d[dig_n] & blink_off_d)
              | (sh_lz_d & lz_hide(sh_dig_d, dig_n));
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_d == ST_DRIVE) begin
            an_d  = ~(4'b0001 << dig_n);
            seg_d = hide ? SEG_BLANK : code;
            dp_d  = hide ? 1'b1 : ~sh_dp_d[dig_n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q     <= 1'b1;
            state_q     <= ST_DEAD;
            idx_q       <= 2'd0;
            blink_off_q <= 1'b0;
            an_o        <= 4'b1111;
            seg_o       <= SEG_BLANK;
            dp_o        <= 1'b1;
            frame_o     <= 1'b0;
        end else begin
            first_q     <= 1'b0;
            state_q     <= state_d;
            idx_q       <= idx_d;
            blink_off_q <= blink_off_d;
            an_o        <= an_d;
            seg_o       <= seg_d;
            dp_o        <= dp_d;
            frame_o     <= snap;
        end
    end

    always_ff @(posedge clk) begin
        sh_dig_q   <= sh_dig_d;
        sh_blank_q <= sh_blank_d;
        sh_blink_q <= sh_blink_d;
        sh_dp_q    <= sh_dp_d;
        sh_lz_q    <= sh_lz_d;
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with CLK_DIV=8, DEAD_CYC=2, BLINK_DIV=4 (one frame = 32 clocks).
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  blank, blink, dp;
    logic        lz_en;
    logic [3:0]  seg_o, an_o;
    logic        dp_o, frame_o;
    logic        done = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.CLK_DIV(8), .DEAD_CYC(2), .BLINK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digits_i (digits),
        .blank_i  (blank),
        .blink_i  (blink),
        .dp_i     (dp),
        .lz_en_i  (lz_en),
        .seg_o    (seg_o),
        .an_o     (an_o),
        .dp_o     (dp_o),
        .frame_o  (frame_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // At most one digit enable may be low at any time.
    always @(negedge clk) begin
        if (!done) chk("onehot", {31'd0, ($countones(~an_o) <= 1)}, 32'd1);
    end

    // Checks one 32-clock frame starting at the snapshot edge. exp_seg = {d3,d2,d1,d0} codes,
    // exp_dp = expected dp pin per digit. Optionally changes digits_i after cycle chg_c.
    task automatic run_frame(input logic [15:0] exp_seg, input logic [3:0] exp_dp,
                             input int chg_c, input logic [15:0] chg_val);
        for (int c = 0; c < 32; c++) begin
            int slot;
            int p;
            int n;
            @(posedge clk);
            #1;
            slot = c / 8;
            p    = c % 8;
            n    = 3 - slot;
            chk("frame", {31'd0, frame_o}, {31'd0, (c == 0)});
            if (p < 2) begin
                chk("an_dead", {28'd0, an_o}, 32'hF);
                chk("seg_dead", {28'd0, seg_o}, 32'hF);
                chk("dp_dead", {31'd0, dp_o}, 32'd1);
            end else begin
                chk("an", {28'd0, an_o}, {28'd0, ~(4'b0001 << n)});
                chk("seg", {28'd0, seg_o}, {28'd0, exp_seg[n*4 +: 4]});
                chk("dp", {31'd0, dp_o}, {31'd0, exp_dp[n]});
            end
            if (c == chg_c) digits = chg_val;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        digits = 16'h1234;
        blank  = 4'h0;
        blink  = 4'h0;
        dp     = 4'h0;
        lz_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", {28'd0, an_o}, 32'hF);
        chk("rst_seg", {28'd0, seg_o}, 32'hF);
        chk("rst_dp", {31'd0, dp_o}, 32'd1);
        chk("rst_frame", {31'd0, frame_o}, 32'd0);
        rst_n = 1'b1;

        // scan order and dead time
        run_frame(16'h1234, 4'hF, -1, 16'h0);
        run_frame(16'h1234, 4'hF, -1, 16'h0);

        // leading-zero suppression
        digits = 16'h0005; lz_en = 1'b1;
        run_frame(16'hFFF5, 4'hF, -1, 16'h0);
        digits = 16'h0000;
        run_frame(16'hFFF0, 4'hF, -1, 16'h0);

        // blink on d0 with decimal point; phase flips every frame
        lz_en = 1'b0; digits = 16'h1234; blink = 4'b0001; dp = 4'b0001;
        run_frame(16'h1234, 4'b1110, -1, 16'h0);
        run_frame(16'h123F, 4'b1111, -1, 16'h0);
        run_frame(16'h1234, 4'b1110, -1, 16'h0);
        run_frame(16'h123F, 4'b1111, -1, 16'h0);

        // snapshot: mid-frame change shows only next frame
        blink = 4'h0; dp = 4'h0; digits = 16'h1111;
        run_frame(16'h1111, 4'hF, 11, 16'h2222);
        run_frame(16'h2222, 4'hF, -1, 16'h0);

        // out-of-range codes pass through
        digits = 16'hABCF;
        run_frame(16'hABCF, 4'hF, -1, 16'h0);

        // reset while d2 is driven
        repeat (11) @(posedge clk);
        #1;
        chk("pre_rst_an", {28'd0, an_o}, 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_an", {28'd0, an_o}, 32'hF);
        chk("arst_seg", {28'd0, seg_o}, 32'hF);
        chk("arst_dp", {31'd0, dp_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("hold_an", {28'd0, an_o}, 32'hF);
        chk("hold_frame", {31'd0, frame_o}, 32'd0);
        rst_n = 1'b1;
        run_frame(16'hABCF, 4'hF, -1, 16'h0);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
